// File: rtl/hazard_pkg.sv
// hazard_pkg: shared scoreboard entry type, FSM encodings and forward-select constants.
package hazard_pkg;
   localparam int MAX_AW = 8;
   localparam int FWD_RF = 0;
   typedef enum logic [1:0] {RUN = 2'd0, HAZARD = 2'd1, FREEZE = 2'd2} hazState_t;
   typedef struct packed {
      logic              valid;
      logic [MAX_AW-1:0] rd;
      logic              wr;
      logic              isLoad;
   } sbEntry_t;
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shift register of in-flight instructions after ID, held while frozen.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 freeze,
   input  sbEntry_t             entryIn,
   output sbEntry_t [DEPTH-1:0] entries
);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         entries <= '0;
      end else if (!freeze) begin
         entries[0] <= entryIn;
         for (int k = 1; k < DEPTH; k++) entries[k] <= entries[k-1];
      end
   end
endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: stall/bubble/flush/forward control; operand forwarding enabled by HAZARD_FORWARDING_EN.
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW      = 3,
   parameter int TRACK_DEPTH = 3,
   parameter int CNT_W       = 16,
   localparam int FW         = $clog2(TRACK_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_rd_wr,
   input  logic              id_is_load,
   input  logic              id_branch_taken,
   input  logic              mem_busy,
   output logic              stall,
   output logic              bubble,
   output logic              pc_src,
   output logic              kill,
   output logic [FW-1:0]     fwd_a,
   output logic [FW-1:0]     fwd_b,
   output logic [1:0]        state,
   output logic [CNT_W-1:0]  stall_cnt
);
   sbEntry_t [TRACK_DEPTH-1:0] entries;
   sbEntry_t                   entryIn;
   logic [TRACK_DEPTH-1:0]     m1, m2;
   logic                       hazard;
   hazState_t                  stateReg, nextState;

   hazard_scoreboard #(.DEPTH(TRACK_DEPTH)) scoreboard (
      .clk(clk), .rst_n(rst_n), .freeze(mem_busy), .entryIn(entryIn), .entries(entries)
   );

   always_comb begin
      m1 = '0;
      m2 = '0;
      for (int k = 0; k < TRACK_DEPTH; k++) begin
         m1[k] = id_valid & id_rs1_used & entries[k].valid & entries[k].wr & (entries[k].rd == MAX_AW'(id_rs1));
         m2[k] = id_valid & id_rs2_used & entries[k].valid & entries[k].wr & (entries[k].rd == MAX_AW'(id_rs2));
      end
   end

`ifdef HAZARD_FORWARDING_EN
   logic [TRACK_DEPTH-1:0] f1, f2;

   // Lowest index wins: the youngest in-flight producer holds the newest value.
   function automatic logic [FW-1:0] pickFwd(input logic [TRACK_DEPTH-1:0] m);
      pickFwd = FW'(FWD_RF);
      for (int k = TRACK_DEPTH - 1; k >= 0; k--) if (m[k]) pickFwd = FW'(k + 1);
   endfunction

   always_comb begin
      f1 = m1;
      f2 = m2;
      f1[0] = m1[0] & ~entries[0].isLoad;
      f2[0] = m2[0] & ~entries[0].isLoad;
      hazard = rst_n & entries[0].isLoad & (m1[0] | m2[0]);
      fwd_a = rst_n ? pickFwd(f1) : FW'(FWD_RF);
      fwd_b = rst_n ? pickFwd(f2) : FW'(FWD_RF);
   end
`else
   always_comb begin
      hazard = rst_n & (|m1 | |m2);
      fwd_a = FW'(FWD_RF);
      fwd_b = FW'(FWD_RF);
   end
`endif

   // A freeze overrides a pending hazard; the hazard is seen again once memory releases.
   always_comb begin
      stall = rst_n & (mem_busy | hazard);
      bubble = rst_n & ~mem_busy & hazard;
      pc_src = rst_n & id_valid & id_branch_taken & ~stall;
      kill = pc_src;
      entryIn = '{valid: id_valid & ~stall, rd: MAX_AW'(id_rd), wr: id_rd_wr, isLoad: id_is_load};
   end

   always_ff @(posedge clk) stateReg <= !rst_n ? RUN : nextState;

   always_comb nextState = mem_busy ? FREEZE : hazard ? HAZARD : RUN;

   always_comb state = stateReg;

   always_ff @(posedge clk) begin
      if (!rst_n) stall_cnt <= '0;
      else if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
   end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed vector table plus freeze/reset sequences for hazard_control_unit.
module tb_hazard_control_unit;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       idValid, rs1Used, rs2Used, rdWr, isLoad, brTaken, memBusy;
   logic [2:0] rs1, rs2, rd;
   logic       stall, bubble, pcSrc, kill;
   logic [1:0] fwdA, fwdB, state;
   logic [15:0] stallCnt;
   logic       stall2, bubble2, pcSrc2, kill2;
   logic [1:0] fwdA2, fwdB2, state2;
   logic [1:0] stallCnt2;
   int         total = 0;
   int         bad = 0;

   typedef struct {
      logic       v;
      logic [2:0] rs1, rs2;
      logic       u1, u2;
      logic [2:0] rd;
      logic       wr, ld, br, busy;
      logic       eStall, eBubble, ePc, eKill;
      logic [1:0] eFa, eFb, eState;
   } vec_t;
   vec_t vecs[$];

   always #5 clk = ~clk;

   hazard_control_unit dut (
      .clk(clk), .rst_n(rst_n), .id_valid(idValid), .id_rs1(rs1), .id_rs2(rs2),
      .id_rs1_used(rs1Used), .id_rs2_used(rs2Used), .id_rd(rd), .id_rd_wr(rdWr),
      .id_is_load(isLoad), .id_branch_taken(brTaken), .mem_busy(memBusy),
      .stall(stall), .bubble(bubble), .pc_src(pcSrc), .kill(kill),
      .fwd_a(fwdA), .fwd_b(fwdB), .state(state), .stall_cnt(stallCnt)
   );

   hazard_control_unit #(.CNT_W(2)) dutSat (
      .clk(clk), .rst_n(rst_n), .id_valid(idValid), .id_rs1(rs1), .id_rs2(rs2),
      .id_rs1_used(rs1Used), .id_rs2_used(rs2Used), .id_rd(rd), .id_rd_wr(rdWr),
      .id_is_load(isLoad), .id_branch_taken(brTaken), .mem_busy(memBusy),
      .stall(stall2), .bubble(bubble2), .pc_src(pcSrc2), .kill(kill2),
      .fwd_a(fwdA2), .fwd_b(fwdB2), .state(state2), .stall_cnt(stallCnt2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic chkOut(input string tag, input logic s, b, p, k, input logic [1:0] fa, fb);
      chk({tag, " stall"}, stall, s);
      chk({tag, " bubble"}, bubble, b);
      chk({tag, " pc_src"}, pcSrc, p);
      chk({tag, " kill"}, kill, k);
      chk({tag, " fwd_a"}, fwdA, fa);
      chk({tag, " fwd_b"}, fwdB, fb);
   endtask

   task automatic drive(input vec_t t);
      idValid = t.v; rs1 = t.rs1; rs2 = t.rs2; rs1Used = t.u1; rs2Used = t.u2;
      rd = t.rd; rdWr = t.wr; isLoad = t.ld; brTaken = t.br; memBusy = t.busy;
   endtask

   task automatic idle();
      idValid = 0; rs1 = 0; rs2 = 0; rs1Used = 0; rs2Used = 0;
      rd = 0; rdWr = 0; isLoad = 0; brTaken = 0; memBusy = 0;
   endtask

   task automatic doReset();
      rst_n = 0;
      idle();
      @(posedge clk); #1;
      rst_n = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef HAZARD_FORWARDING_EN
      //              v rs1 rs2 u1 u2 rd wr ld br busy  S B P K fa fb st
      vecs.push_back('{1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0});
      vecs.push_back('{1, 3, 0, 1, 0, 4, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0});
      vecs.push_back('{1, 0, 3, 0, 1, 6, 1, 0, 0, 0,  0, 0, 0, 0, 0, 2, 0});
      vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0});
      vecs.push_back('{1, 6, 0, 1, 0, 5, 1, 1, 0, 0,  0, 0, 0, 0, 2, 0, 0});
      vecs.push_back('{1, 5, 0, 1, 0, 7, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 1});
      vecs.push_back('{1, 5, 0, 1, 0, 7, 1, 0, 0, 0,  0, 0, 0, 0, 2, 0, 0});
      vecs.push_back('{1, 7, 0, 1, 0, 0, 0, 0, 1, 0,  0, 0, 1, 1, 1, 0, 0});
      vecs.push_back('{1, 0, 0, 0, 0, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0});
      vecs.push_back('{1, 1, 0, 1, 0, 0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 1});
      vecs.push_back('{1, 1, 0, 1, 0, 0, 0, 0, 1, 0,  0, 0, 1, 1, 2, 0, 0});
      vecs.push_back('{1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0});
      vecs.push_back('{1, 0, 0, 1, 1, 2, 1, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0});
      vecs.push_back('{1, 0, 2, 0, 1, 3, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0});
`else
      //              v rs1 rs2 u1 u2 rd wr ld br busy  S B P K fa fb st
      vecs.push_back('{1, 0, 0, 0, 0, 2, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0});
      vecs.push_back('{1, 2, 0, 1, 0, 3, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 1});
      vecs.push_back('{1, 2, 0, 1, 0, 3, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 1});
      vecs.push_back('{1, 2, 0, 1, 0, 3, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 1});
      vecs.push_back('{1, 2, 0, 1, 0, 3, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0});
      vecs.push_back('{1, 3, 0, 1, 0, 0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 1});
      vecs.push_back('{1, 3, 0, 1, 0, 0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 1});
      vecs.push_back('{1, 3, 0, 1, 0, 0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 1});
      vecs.push_back('{1, 3, 0, 1, 0, 0, 0, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0});
      vecs.push_back('{1, 0, 0, 0, 0, 4, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0});
      vecs.push_back('{1, 4, 4, 0, 1, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 1});
`endif

      // Reset: outputs quiet even with busy/branch asserted
      rst_n = 0;
      idle();
      memBusy = 1; idValid = 1; brTaken = 1;
      #1;
      chkOut("in_reset", 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("reset state", state, 0);
      chk("reset stall_cnt", stallCnt, 0);
      chkOut("in_reset2", 0, 0, 0, 0, 0, 0);
      doReset();
      #2;
      chkOut("after_reset", 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         #2;
         chkOut($sformatf("v%0d", i), vecs[i].eStall, vecs[i].eBubble, vecs[i].ePc,
                vecs[i].eKill, vecs[i].eFa, vecs[i].eFb);
         @(posedge clk); #1;
         chk($sformatf("v%0d state", i), state, vecs[i].eState);
      end
`ifdef HAZARD_FORWARDING_EN
      chk("table stall_cnt", stallCnt, 2);
      chk("table sat_cnt", stallCnt2, 2);
`else
      chk("table stall_cnt", stallCnt, 7);
      chk("table sat_cnt", stallCnt2, 3);
`endif

      // Load-use held behind a 4-cycle memory freeze, branch pending in ID
      doReset();
      idValid = 1; rd = 5; rdWr = 1; isLoad = 1;
      @(posedge clk); #1;
      idValid = 1; rs1 = 5; rs1Used = 1; rd = 6; rdWr = 1; isLoad = 0; brTaken = 1; memBusy = 1;
      for (int c = 0; c < 4; c++) begin
         #2;
         chkOut($sformatf("freeze%0d", c), 1, 0, 0, 0, 0, 0);
         @(posedge clk); #1;
         chk($sformatf("freeze%0d state", c), state, 2);
      end
      memBusy = 0;
      #2;
      chkOut("release", 1, 1, 0, 0, 0, 0);
      chk("release state", state, 2);
      @(posedge clk); #1;
      chk("post hazard state", state, 1);
      chk("freeze stall_cnt", stallCnt, 5);
      chk("freeze sat_cnt", stallCnt2, 3);
      #1;
`ifdef HAZARD_FORWARDING_EN
      chkOut("resume", 0, 0, 1, 1, 2, 0);
`else
      chkOut("resume", 1, 1, 0, 0, 0, 0);
`endif
      @(posedge clk); #1;

      // Reset asserted in the middle of a freeze
      idle();
      memBusy = 1;
      @(posedge clk); #1;
      chk("prereset state", state, 2);
      rst_n = 0;
      #2;
      chkOut("reset_in_freeze", 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("freeze reset state", state, 0);
      chk("freeze reset stall_cnt", stallCnt, 0);
      rst_n = 1;
      memBusy = 0;
      idValid = 1; rs1 = 5; rs1Used = 1; rs2 = 6; rs2Used = 1; rd = 1; rdWr = 1;
      #2;
      chkOut("cleared", 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
